pwm_dac: RTL and testbench

Differential PWM output stage for the sound generator. It accepts signed audio samples from the tone/sequencer stage over a valid/ready handshake and buffers one sample ahead. Each sample is rendered as one fixed-length PWM frame on a pos/neg pin pair, and those pins drive the top-level `uio_out[6]` / `uio_out[7]`. Once per frame it pulses `frame_start` to pace the upstream generator.

---
 rtl/soundgen_pkg.sv | 7 +
 rtl/sample_holdreg.sv | 54 +++++
 rtl/pwm_dac.sv | 91 +++++++++
 tb/tb_pwm_dac.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soundgen_pkg.sv
// Shared types and constants for the sound generator blocks.
package soundgen_pkg;
  localparam int SAMPLE_W  = 8;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  // One PWM frame covers the full magnitude range of a signed sample.
  localparam int FRAME_LEN = 1 << (SAMPLE_W - 1);
endpackage

// File: rtl/sample_holdreg.sv
// One-entry pending buffer between the upstream generator and the PWM frame loader.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   data_i / valid_i  upstream sample and its valid
//   ready_o           slot empty (combinational from the full flag)
//   load_i            consume strobe from the frame boundary
//   data_o / valid_o  sample offered to the loader; when empty, an incoming
//                     sample is passed straight through so a transfer on the
//                     boundary cycle is loaded on that same edge
module sample_holdreg
  import soundgen_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         load_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);
  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         xfer;

  assign ready_o = !full_q;
  assign xfer    = valid_i && !full_q;
  assign valid_o = full_q || valid_i;
  assign data_o  = full_q ? data_q : data_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (xfer) begin
      data_d = data_i;
      // Accepted and loaded on the same edge: never becomes pending.
      full_d = !load_i;
    end else if (load_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/pwm_dac.sv
// Differential PWM output stage. Each signed sample is rendered as one frame of
// 2^(WIDTH-1) slots; the magnitude sets the pulse width on pwm_pos (positive)
// or pwm_neg (negative). One sample is buffered ahead in sample_holdreg.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   sample / sample_valid       upstream two's-complement sample
//   sample_ready                pending slot empty
//   pwm_pos / pwm_neg           registered pin drive
//   frame_start                 high in slot 0 of every frame
//   underrun                    high in slot 0 of a frame replaying the old sample
module pwm_dac
  import soundgen_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_pos,
  output logic             pwm_neg,
  output logic             frame_start,
  output logic             underrun
);
  localparam int SW = WIDTH - 1;

  // slot_q is the slot whose pin values are computed this cycle and appear
  // on the registered pins after the next edge.
  logic [SW-1:0]    slot_q, slot_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic             first_q;   // suppresses underrun on the first frame after reset
  logic             pos_q, neg_q, fs_q, ur_q;
  logic             pos_d, neg_d, fs_d, ur_d;

  logic             boundary, load, hold_vld, is_neg;
  logic [WIDTH-1:0] hold_data, mag_raw;
  logic [SW-1:0]    mag;

  sample_holdreg #(.W(WIDTH)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (sample),
    .valid_i (sample_valid),
    .ready_o (sample_ready),
    .load_i  (load),
    .data_o  (hold_data),
    .valid_o (hold_vld)
  );

  assign boundary = (slot_q == '0);
  assign load     = boundary && hold_vld;
  assign act_d    = load ? hold_data : act_q;
  assign slot_d   = slot_q + SW'(1);

  // |act| saturated to FRAME-1, so the last slot is always dead and the most
  // negative sample maps to a full-minus-one pulse.
  assign is_neg  = act_d[WIDTH-1];
  assign mag_raw = is_neg ? ('0 - act_d) : act_d;
  assign mag     = mag_raw[WIDTH-1] ? '1 : mag_raw[SW-1:0];

  assign pos_d = !is_neg && (act_d != '0) && (slot_q < mag);
  assign neg_d = is_neg && (slot_q < mag);
  assign fs_d  = boundary;
  assign ur_d  = boundary && !hold_vld && !first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      act_q   <= '0;
      first_q <= 1'b1;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      act_q   <= act_d;
      first_q <= 1'b0;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

  assign pwm_pos     = pos_q;
  assign pwm_neg     = neg_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;
endmodule

// File: tb/tb_pwm_dac.sv
module tb_pwm_dac;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       sample_ready, pwm_pos, pwm_neg, frame_start, underrun;

  int checks = 0;
  int errors = 0;

  logic pos_a[128], neg_a[128], fs_a[128], ur_a[128], rdy_a[128];

  always #5 clk = ~clk;

  pwm_dac #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_pos      (pwm_pos),
    .pwm_neg      (pwm_neg),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  function automatic int n_pos();
    int n = 0;
    for (int k = 0; k < 128; k++) n += int'(pos_a[k]);
    return n;
  endfunction

  function automatic int n_neg();
    int n = 0;
    for (int k = 0; k < 128; k++) n += int'(neg_a[k]);
    return n;
  endfunction

  function automatic int n_both();
    int n = 0;
    for (int k = 0; k < 128; k++) n += int'(pos_a[k] & neg_a[k]);
    return n;
  endfunction

  function automatic int n_fs();
    int n = 0;
    for (int k = 0; k < 128; k++) n += int'(fs_a[k]);
    return n;
  endfunction

  function automatic int n_ur();
    int n = 0;
    for (int k = 0; k < 128; k++) n += int'(ur_a[k]);
    return n;
  endfunction

  // Pulse reset; the next negedge after return observes slot 0 of frame 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Observe one frame (must start at slot 0). Valid is driven for slots
  // [vs, ve) with v0 in the first such slot and v1 afterwards.
  task automatic capture_frame(input int vs, input int ve,
                               input logic [7:0] v0, input logic [7:0] v1);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      pos_a[k] = pwm_pos;
      neg_a[k] = pwm_neg;
      fs_a[k]  = frame_start;
      ur_a[k]  = underrun;
      rdy_a[k] = sample_ready;
      if (k >= vs && k < ve) begin
        sample_valid = 1'b1;
        sample = (k == vs) ? v0 : v1;
      end else begin
        sample_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_pos, pwm_neg, frame_start, underrun} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {pwm_pos, pwm_neg, frame_start, underrun});
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", sample_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture_frame(0, 1, 8'd127, 8'd127);
    checks++;
    if (fs_a[0] !== 1'b1 || n_fs() != 1) begin
      errors++; $display("FAIL frame0_start: got fs0=%b count=%0d expected 1/1", fs_a[0], n_fs());
    end
    checks++;
    if (ur_a[0] !== 1'b0) begin
      errors++; $display("FAIL frame0_underrun: got %b expected 0", ur_a[0]);
    end
    checks++;
    if (n_pos() + n_neg() != 0) begin
      errors++; $display("FAIL frame0_pins: got %0d high cycles expected 0", n_pos() + n_neg());
    end
    // Frame 1 plays +127; park a second sample in pending, then reset at slot 40.
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      sample_valid = (k == 10);
      sample = 8'd50;
      if (k == 0) begin
        checks++;
        if (frame_start !== 1'b1) begin
          errors++; $display("FAIL frame1_start: got %b expected 1", frame_start);
        end
      end
    end
    checks++;
    if (pwm_pos !== 1'b1) begin
      errors++; $display("FAIL slot40_pos: got %b expected 1", pwm_pos);
    end
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++; $display("FAIL slot40_pending: got ready=%b expected 0", sample_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_pos, pwm_neg, frame_start, underrun} !== 4'b0000) begin
      errors++; $display("FAIL midreset_outputs: got %b expected 0000", {pwm_pos, pwm_neg, frame_start, underrun});
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready: got %b expected 1", sample_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    capture_frame(-1, -1, 8'd0, 8'd0);
    checks++;
    if (fs_a[0] !== 1'b1 || n_fs() != 1 || ur_a[0] !== 1'b0) begin
      errors++; $display("FAIL restart_frame0: got fs0=%b fsn=%0d ur0=%b expected 1/1/0", fs_a[0], n_fs(), ur_a[0]);
    end
    capture_frame(-1, -1, 8'd0, 8'd0);
    n = n_pos() + n_neg();
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL pending_discarded: got %0d high cycles expected 0", n);
    end
    checks++;
    if (fs_a[0] !== 1'b1 || n_fs() != 1 || ur_a[0] !== 1'b1) begin
      errors++; $display("FAIL restart_frame1: got fs0=%b fsn=%0d ur0=%b expected 1/1/1", fs_a[0], n_fs(), ur_a[0]);
    end
  endtask

  task automatic test_positive();
    do_reset();
    capture_frame(0, 1, 8'd64, 8'd64);
    checks++;
    if (rdy_a[0] !== 1'b1 || rdy_a[1] !== 1'b0) begin
      errors++; $display("FAIL pos_ready_fall: got %b%b expected 10", rdy_a[0], rdy_a[1]);
    end
    capture_frame(-1, -1, 8'd0, 8'd0);
    checks++;
    if (n_pos() != 64 || pos_a[0] !== 1'b1 || pos_a[63] !== 1'b1 || pos_a[64] !== 1'b0) begin
      errors++; $display("FAIL pos64_pulse: got count=%0d s0=%b s63=%b s64=%b expected 64/1/1/0",
                         n_pos(), pos_a[0], pos_a[63], pos_a[64]);
    end
    checks++;
    if (n_neg() != 0) begin
      errors++; $display("FAIL pos64_neg: got %0d expected 0", n_neg());
    end
    checks++;
    if (rdy_a[0] !== 1'b1 || ur_a[0] !== 1'b0) begin
      errors++; $display("FAIL pos64_slot0: got ready=%b ur=%b expected 1/0", rdy_a[0], ur_a[0]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    capture_frame(0, 1, 8'h80, 8'h80);
    capture_frame(5, 6, 8'hFF, 8'hFF);
    checks++;
    if (n_neg() != 127 || neg_a[126] !== 1'b1 || neg_a[127] !== 1'b0) begin
      errors++; $display("FAIL sat_m128: got count=%0d s126=%b s127=%b expected 127/1/0",
                         n_neg(), neg_a[126], neg_a[127]);
    end
    checks++;
    if (n_pos() != 0) begin
      errors++; $display("FAIL sat_m128_pos: got %0d expected 0", n_pos());
    end
    capture_frame(-1, -1, 8'd0, 8'd0);
    checks++;
    if (n_neg() != 1 || neg_a[0] !== 1'b1 || n_pos() != 0) begin
      errors++; $display("FAIL sat_m1: got neg=%0d s0=%b pos=%0d expected 1/1/0", n_neg(), neg_a[0], n_pos());
    end
  endtask

  task automatic test_reversal();
    int p1, both1;
    logic p126, p127;
    do_reset();
    capture_frame(0, 1, 8'd127, 8'd127);
    capture_frame(0, 1, 8'h81, 8'h81);
    p1 = n_pos(); both1 = n_both(); p126 = pos_a[126]; p127 = pos_a[127];
    capture_frame(-1, -1, 8'd0, 8'd0);
    checks++;
    if (both1 + n_both() != 0) begin
      errors++; $display("FAIL rev_overlap: got %0d expected 0", both1 + n_both());
    end
    checks++;
    if (p1 != 127 || n_neg() != 127) begin
      errors++; $display("FAIL rev_widths: got pos=%0d neg=%0d expected 127/127", p1, n_neg());
    end
    checks++;
    if (p126 !== 1'b1 || p127 !== 1'b0 || neg_a[0] !== 1'b1) begin
      errors++; $display("FAIL rev_deadslot: got p126=%b p127=%b n0=%b expected 1/0/1", p126, p127, neg_a[0]);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    capture_frame(0, 1, 8'd10, 8'd10);
    capture_frame(-1, -1, 8'd0, 8'd0);
    checks++;
    if (ur_a[0] !== 1'b0 || n_pos() != 10) begin
      errors++; $display("FAIL ur_frame1: got ur=%b pos=%0d expected 0/10", ur_a[0], n_pos());
    end
    capture_frame(-1, -1, 8'd0, 8'd0);
    checks++;
    if (ur_a[0] !== 1'b1 || n_ur() != 1) begin
      errors++; $display("FAIL ur_frame2_flag: got ur0=%b count=%0d expected 1/1", ur_a[0], n_ur());
    end
    checks++;
    if (n_pos() != 10 || pos_a[9] !== 1'b1 || pos_a[10] !== 1'b0) begin
      errors++; $display("FAIL ur_frame2_repeat: got pos=%0d expected 10", n_pos());
    end
  endtask

  task automatic test_back_to_back();
    int rdy_hi;
    do_reset();
    capture_frame(0, 128, 8'd20, 8'd30);
    rdy_hi = 0;
    for (int k = 1; k < 128; k++) rdy_hi += int'(rdy_a[k]);
    checks++;
    if (rdy_a[0] !== 1'b1 || rdy_hi != 0) begin
      errors++; $display("FAIL bp_ready_low: got ready0=%b high_after=%0d expected 1/0", rdy_a[0], rdy_hi);
    end
    capture_frame(0, 1, 8'd30, 8'd30);
    checks++;
    if (rdy_a[0] !== 1'b1 || rdy_a[1] !== 1'b0) begin
      errors++; $display("FAIL bp_ready_rise: got %b%b expected 10", rdy_a[0], rdy_a[1]);
    end
    checks++;
    if (n_pos() != 20 || ur_a[0] !== 1'b0) begin
      errors++; $display("FAIL bp_frame1: got pos=%0d ur=%b expected 20/0", n_pos(), ur_a[0]);
    end
    capture_frame(-1, -1, 8'd0, 8'd0);
    checks++;
    if (n_pos() != 30 || ur_a[0] !== 1'b0) begin
      errors++; $display("FAIL bp_frame2: got pos=%0d ur=%b expected 30/0", n_pos(), ur_a[0]);
    end
    capture_frame(-1, -1, 8'd0, 8'd0);
    checks++;
    if (n_pos() != 30 || ur_a[0] !== 1'b1) begin
      errors++; $display("FAIL bp_frame3: got pos=%0d ur=%b expected 30/1", n_pos(), ur_a[0]);
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_saturation();
    test_reversal();
    test_underrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
